// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - block modes, FSM states, zigzag table and per-mode scan bounds
package cavlc_pkg;

  typedef enum logic [1:0] {
    MODE_LUMA      = 2'd0,
    MODE_AC        = 2'd1,
    MODE_CHROMA_DC = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LEN_LUMA      = 16;
  localparam int LEN_AC        = 15;
  localparam int LEN_CHROMA_DC = 4;

  // Scan index -> raster position of a 4x4 block (frame zigzag).
  localparam logic [3:0] ZIGZAG [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  // Highest scan index visited for a block type (scan starts here).
  function automatic logic [3:0] last_idx(input mode_e m);
    return (m == MODE_CHROMA_DC) ? 4'(LEN_CHROMA_DC - 1) : 4'(LEN_LUMA - 1);
  endfunction

  // Lowest scan index visited; AC blocks skip the DC position.
  function automatic logic [3:0] first_idx(input mode_e m);
    return (m == MODE_AC) ? 4'(LEN_LUMA - LEN_AC) : 4'd0;
  endfunction

endpackage

// File: rtl/cavlc_scan_buffer.sv
// rtl/cavlc_scan_buffer.sv - captured coefficient block with scan-order read port
module cavlc_scan_buffer
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [16*COEFF_W-1:0]  i_coeff,
  input  logic                   i_direct,
  input  logic [3:0]             i_scan_idx,
  output logic [COEFF_W-1:0]     o_coeff
);

  logic [16*COEFF_W-1:0] r_coeffs;
  logic [3:0]            w_pos;

  // Capture the whole raster block when the analyzer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coeffs <= '0;
    end else if (i_load) begin
      r_coeffs <= i_coeff;
    end
  end

  // Chroma DC walks raster order directly; 4x4 blocks go through the zigzag table.
  assign w_pos   = i_direct ? i_scan_idx : ZIGZAG[i_scan_idx];
  assign o_coeff = r_coeffs[int'(w_pos)*COEFF_W +: COEFF_W];

endmodule

// File: rtl/cavlc_coeff_analyzer.sv
// rtl/cavlc_coeff_analyzer.sv - CAVLC coefficient statistics for one residual block
module cavlc_coeff_analyzer
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = 8,
  parameter int MAX_N   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [16*COEFF_W-1:0]    in_coeff,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               total_coeff,
  output logic [1:0]               t1_cnt,
  output logic [2:0]               t1_sign,
  output logic [4:0]               total_zeros,
  output logic [4:0]               level_cnt,
  output logic [MAX_N*COEFF_W-1:0] level_list,
  output logic [4:0]               run_cnt,
  output logic [MAX_N*5-1:0]       run_list,
  output logic                     mode_err
);

  state_e                   r_state;
  mode_e                    r_mode;
  logic [3:0]               r_idx;
  logic [4:0]               r_total_coeff;
  logic [4:0]               r_total_zeros;
  logic [4:0]               r_level_cnt;
  logic [4:0]               r_run_cnt;
  logic [4:0]               r_run;
  logic [1:0]               r_t1_cnt;
  logic [2:0]               r_t1_sign;
  logic [MAX_N*COEFF_W-1:0] r_level_list;
  logic [MAX_N*5-1:0]       r_run_list;
  logic                     r_mode_err;

  mode_e                    w_in_mode;
  logic                     w_accept;
  logic [COEFF_W-1:0]       w_coeff;
  logic                     w_nz;
  logic                     w_is_one;
  logic                     w_is_t1;

  // Reserved mode is scanned like a luma block; the error flag records it.
  assign w_in_mode = (in_mode == MODE_RSVD) ? MODE_LUMA : mode_e'(in_mode);
  assign w_accept  = (r_state == ST_IDLE) && in_valid;

  cavlc_scan_buffer #(
    .COEFF_W (COEFF_W)
  ) u_scan_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_coeff    (in_coeff),
    .i_direct   (r_mode == MODE_CHROMA_DC),
    .i_scan_idx (r_idx),
    .o_coeff    (w_coeff)
  );

  assign w_nz     = (w_coeff != '0);
  assign w_is_one = (w_coeff == COEFF_W'(1)) || (w_coeff == {COEFF_W{1'b1}});
  // A +/-1 is a trailing one only until three are seen or a real level breaks the run.
  assign w_is_t1  = w_is_one && (r_t1_cnt != 2'd3) && (r_level_cnt == 5'd0);

  // Control FSM plus all statistics registers, updated one coefficient per scan cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_LUMA;
      r_idx         <= 4'd0;
      r_total_coeff <= 5'd0;
      r_total_zeros <= 5'd0;
      r_level_cnt   <= 5'd0;
      r_run_cnt     <= 5'd0;
      r_run         <= 5'd0;
      r_t1_cnt      <= 2'd0;
      r_t1_sign     <= 3'd0;
      r_level_list  <= '0;
      r_run_list    <= '0;
      r_mode_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mode        <= w_in_mode;
            r_mode_err    <= (in_mode == MODE_RSVD);
            r_idx         <= last_idx(w_in_mode);
            r_total_coeff <= 5'd0;
            r_total_zeros <= 5'd0;
            r_level_cnt   <= 5'd0;
            r_run_cnt     <= 5'd0;
            r_run         <= 5'd0;
            r_t1_cnt      <= 2'd0;
            r_t1_sign     <= 3'd0;
            r_level_list  <= '0;
            r_run_list    <= '0;
            r_state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_nz) begin
            r_total_coeff <= r_total_coeff + 5'd1;
            // The first nonzero has no run before it; later ones close the pending run.
            if (r_total_coeff != 5'd0) begin
              if (int'(r_run_cnt) < MAX_N) begin
                r_run_list[int'(r_run_cnt)*5 +: 5] <= r_run;
              end
              r_run_cnt <= r_run_cnt + 5'd1;
              r_run     <= 5'd0;
            end
            if (w_is_t1) begin
              r_t1_sign[r_t1_cnt] <= w_coeff[COEFF_W-1];
              r_t1_cnt            <= r_t1_cnt + 2'd1;
            end else begin
              if (int'(r_level_cnt) < MAX_N) begin
                r_level_list[int'(r_level_cnt)*COEFF_W +: COEFF_W] <= w_coeff;
              end
              r_level_cnt <= r_level_cnt + 5'd1;
            end
          end else if (r_total_coeff != 5'd0) begin
            r_total_zeros <= r_total_zeros + 5'd1;
            r_run         <= r_run + 5'd1;
          end
          if (r_idx == first_idx(r_mode)) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign total_coeff = r_total_coeff;
  assign t1_cnt      = r_t1_cnt;
  assign t1_sign     = r_t1_sign;
  assign total_zeros = r_total_zeros;
  assign level_cnt   = r_level_cnt;
  assign level_list  = r_level_list;
  assign run_cnt     = r_run_cnt;
  assign run_list    = r_run_list;
  assign mode_err    = r_mode_err;

endmodule

// File: tb/tb_cavlc_coeff_analyzer.sv
// tb/tb_cavlc_coeff_analyzer.sv - directed self-checking bench for cavlc_coeff_analyzer
module tb_cavlc_coeff_analyzer;

  localparam int CW   = 8;
  localparam int MAXN = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [16*CW-1:0]      in_coeff;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            total_coeff;
  logic [1:0]            t1_cnt;
  logic [2:0]            t1_sign;
  logic [4:0]            total_zeros;
  logic [4:0]            level_cnt;
  logic [MAXN*CW-1:0]    level_list;
  logic [4:0]            run_cnt;
  logic [MAXN*5-1:0]     run_list;
  logic                  mode_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] zz [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                          4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};

  logic [MAXN*CW-1:0] exp_lv;
  logic [MAXN*5-1:0]  exp_rl;
  logic [25:0]        exp_sum;
  logic [25:0]        got_sum;
  int                 lat;

  cavlc_coeff_analyzer #(.COEFF_W(CW), .MAX_N(MAXN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_coeff    (in_coeff),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .total_coeff (total_coeff),
    .t1_cnt      (t1_cnt),
    .t1_sign     (t1_sign),
    .total_zeros (total_zeros),
    .level_cnt   (level_cnt),
    .level_list  (level_list),
    .run_cnt     (run_cnt),
    .run_list    (run_list),
    .mode_err    (mode_err)
  );

  always #5 clk = ~clk;

  always_comb got_sum = {total_coeff, t1_cnt, t1_sign, total_zeros, level_cnt, run_cnt, mode_err};

  task automatic put_scan(input int k, input int v);
    in_coeff[int'(zz[k])*CW +: CW] = CW'(v);
  endtask

  task automatic load_luma_example();
    in_coeff = '0;
    put_scan(1, 3); put_scan(2, -1); put_scan(5, -1); put_scan(6, 1); put_scan(8, 1);
  endtask

  task automatic run_block(input logic [1:0] mode, output int latency);
    int t;
    t = 0;
    latency = -1;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    in_mode  = mode;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin latency = c; break; end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_coeff = '0;
    #12;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if (got_sum !== 26'h0) begin n_fail++; $display("FAIL reset counts: got %h expected 0", got_sum); end
    n_checks++; if (level_list !== '0 || run_list !== '0) begin n_fail++; $display("FAIL reset lists: got %h/%h expected 0", level_list, run_list); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset release in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_luma_example();
    load_luma_example();
    run_block(2'd0, lat);
    exp_sum = {5'd5, 2'd3, 3'b100, 5'd4, 5'd2, 5'd4, 1'b0};
    exp_lv = '0; exp_lv[7:0] = 8'hFF; exp_lv[15:8] = 8'h03;
    exp_rl = '0; exp_rl[4:0] = 5'd1; exp_rl[14:10] = 5'd2;
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL luma latency: got %0d expected 16", lat); end
    n_checks++; if (got_sum !== exp_sum) begin n_fail++; $display("FAIL luma counts: got %h expected %h", got_sum, exp_sum); end
    n_checks++; if (level_list !== exp_lv) begin n_fail++; $display("FAIL luma level_list: got %h expected %h", level_list, exp_lv); end
    n_checks++; if (run_list !== exp_rl) begin n_fail++; $display("FAIL luma run_list: got %h expected %h", run_list, exp_rl); end
    consume();
  endtask

  task automatic test_all_zero();
    in_coeff = '0;
    run_block(2'd0, lat);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL zero latency: got %0d expected 16", lat); end
    n_checks++; if (got_sum !== 26'h0) begin n_fail++; $display("FAIL zero counts: got %h expected 0", got_sum); end
    n_checks++; if (level_list !== '0 || run_list !== '0) begin n_fail++; $display("FAIL zero lists: got %h/%h expected 0", level_list, run_list); end
    consume();
  endtask

  task automatic test_chroma_dc();
    in_coeff = '0;
    in_coeff[0*CW +: CW] = 8'h01; in_coeff[1*CW +: CW] = 8'hFF;
    in_coeff[2*CW +: CW] = 8'h01; in_coeff[3*CW +: CW] = 8'h01;
    in_coeff[5*CW +: CW] = 8'h09;
    run_block(2'd2, lat);
    exp_sum = {5'd4, 2'd3, 3'b100, 5'd0, 5'd1, 5'd3, 1'b0};
    exp_lv = '0; exp_lv[7:0] = 8'h01;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL chroma latency: got %0d expected 4", lat); end
    n_checks++; if (got_sum !== exp_sum) begin n_fail++; $display("FAIL chroma counts: got %h expected %h", got_sum, exp_sum); end
    n_checks++; if (level_list !== exp_lv) begin n_fail++; $display("FAIL chroma level_list: got %h expected %h", level_list, exp_lv); end
    n_checks++; if (run_list !== '0) begin n_fail++; $display("FAIL chroma run_list: got %h expected 0", run_list); end
    consume();
  endtask

  task automatic test_ac_and_mode3();
    in_coeff = '0; in_coeff[7:0] = 8'h05;
    run_block(2'd1, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL ac latency: got %0d expected 15", lat); end
    n_checks++; if (got_sum !== 26'h0) begin n_fail++; $display("FAIL ac counts: got %h expected 0", got_sum); end
    n_checks++; if (level_list !== '0) begin n_fail++; $display("FAIL ac level_list: got %h expected 0", level_list); end
    consume();
    load_luma_example();
    run_block(2'd3, lat);
    exp_sum = {5'd5, 2'd3, 3'b100, 5'd4, 5'd2, 5'd4, 1'b1};
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL mode3 latency: got %0d expected 16", lat); end
    n_checks++; if (got_sum !== exp_sum) begin n_fail++; $display("FAIL mode3 counts: got %h expected %h", got_sum, exp_sum); end
    consume();
    n_checks++; if (mode_err !== 1'b1) begin n_fail++; $display("FAIL mode3 err held in idle: got %b expected 1", mode_err); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    in_coeff = '0;
    for (int k = 0; k < 16; k++) put_scan(k, 1);
    run_block(2'd0, lat);
    exp_sum = {5'd16, 2'd3, 3'b000, 5'd0, 5'd13, 5'd15, 1'b0};
    exp_lv = '0;
    for (int i = 0; i < 13; i++) exp_lv[i*CW +: CW] = 8'h01;
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL ones latency: got %0d expected 16", lat); end
    n_checks++; if (got_sum !== exp_sum) begin n_fail++; $display("FAIL ones counts: got %h expected %h", got_sum, exp_sum); end
    n_checks++; if (level_list !== exp_lv) begin n_fail++; $display("FAIL ones level_list: got %h expected %h", level_list, exp_lv); end
    n_checks++; if (run_list !== '0) begin n_fail++; $display("FAIL ones run_list: got %h expected 0", run_list); end
    load_luma_example();
    in_mode = 2'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      ok = out_valid && !in_ready && (got_sum === exp_sum) && (level_list === exp_lv);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL hold cycle %0d: got ov=%b ir=%b sum=%h expected ov=1 ir=0 sum=%h", c, out_valid, in_ready, got_sum, exp_sum); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready after release: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b accept: got in_ready %b expected 0", in_ready); end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    exp_sum = {5'd5, 2'd3, 3'b100, 5'd4, 5'd2, 5'd4, 1'b0};
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL b2b latency: got %0d expected 16", lat); end
    n_checks++; if (got_sum !== exp_sum) begin n_fail++; $display("FAIL b2b counts: got %h expected %h", got_sum, exp_sum); end
    consume();
  endtask

  task automatic test_reset_mid_scan();
    in_coeff = '0;
    for (int k = 0; k < 16; k++) put_scan(k, 1);
    in_mode = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midscan reset state: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
    n_checks++; if (got_sum !== 26'h0) begin n_fail++; $display("FAIL midscan reset counts: got %h expected 0", got_sum); end
    n_checks++; if (level_list !== '0 || run_list !== '0) begin n_fail++; $display("FAIL midscan reset lists: got %h/%h expected 0", level_list, run_list); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midscan release in_ready: got %b expected 1", in_ready); end
    test_chroma_dc();
  endtask

  initial begin
    test_reset();
    test_luma_example();
    test_all_zero();
    test_chroma_dc();
    test_ac_and_mode3();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_analyzer.md
CAVLC_COEFF_ANALYZER -- requirements
Module: cavlc_coeff_analyzer

Interface
REQ-001 SHALL have parameter COEFF_W, default 8, signed coefficient width (valid range 4..16).
REQ-002 SHALL have parameter MAX_N, default 16, list depth and maximum coefficients per block.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  block offered.
REQ-006 SHALL have port in_ready  output  1  block accepted when in_valid & in_ready.
REQ-007 SHALL have port in_mode  input  2  block type: 0 LUMA4x4 (16), 1 AC (15), 2 CHROMA_DC (4), 3 reserved.
REQ-008 SHALL have port in_coeff  input  16*COEFF_W  raster 4x4, element r*4+c at bits [(r*4+c)*COEFF_W +: COEFF_W].
REQ-009 SHALL have port out_valid  output  1  results available.
REQ-010 SHALL have port out_ready  input  1  results consumed when out_valid & out_ready.
REQ-011 SHALL have port total_coeff  output  5  nonzero coefficient count.
REQ-012 SHALL have port t1_cnt  output  2  trailing ones (0..3).
REQ-013 SHALL have port t1_sign  output  3  bit i = 1 when i-th trailing one is negative.
REQ-014 SHALL have port total_zeros  output  5  zeros below the highest-frequency nonzero.
REQ-015 SHALL have port level_cnt / level_list  output  5 / MAX_N*COEFF_W  non-trailing-one levels, reverse scan order.
REQ-016 SHALL have port run_cnt / run_list  output  5 / MAX_N*5  run_before values, reverse scan order.
REQ-017 SHALL have port mode_err  output  1  accepted block had in_mode==3.

Function
REQ-018 SHALL implement states IDLE, SCAN, DONE; in_ready=(IDLE), out_valid=(DONE).
REQ-019 IDLE: on accept SHALL capture in_coeff/in_mode, clear all result registers, load scan index to last position, go SCAN.
REQ-020 Scan order SHALL be zigzag for LUMA (positions 15..0) and AC (positions 15..1, position 0 ignored); CHROMA_DC SHALL use raster elements 3..0 directly.
REQ-021 SCAN SHALL process exactly one coefficient per cycle, high frequency first; after the lowest position go DONE, so out_valid rises N cycles after accept (16/15/4).
REQ-022 Before the first nonzero, zeros SHALL be skipped; afterwards every zero SHALL increment total_zeros and the pending run.
REQ-023 A nonzero of magnitude 1 SHALL count as trailing one while t1_cnt<3 and no non-trailing level has yet been stored; otherwise it SHALL be appended to level_list.
REQ-024 On each nonzero except the first, the pending run SHALL be appended to run_list and cleared; run_cnt SHALL equal max(total_coeff-1,0).
REQ-025 DONE: outputs SHALL hold stable until out_ready; then go IDLE (one bubble between blocks).
REQ-026 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-027 All-zero block SHALL yield every count 0 and empty lists.
REQ-028 Mode 3 SHALL be processed as LUMA with mode_err=1 until the next accept.
REQ-029 Unused list entries SHALL read 0.

Reset
REQ-030 rst SHALL force IDLE, scan index 0, all outputs/lists/counters 0, mode_err 0, independent of clk.
REQ-031 rst during SCAN or DONE SHALL discard the block; in_ready=1 on the first cycle after release.

Structure
REQ-032 Package cavlc_pkg SHALL hold the mode enum, 16-entry zigzag table and per-mode length constants.
REQ-033 Sub-module cavlc_scan_buffer SHALL hold captured coefficients and present the current scan coefficient; counters and FSM stay in cavlc_coeff_analyzer.

Verification
REQ-034 LUMA, scan order 0,3,-1,0,0,-1,1,0,1,0.. -> total_coeff 5, t1_cnt 3, t1_sign 3'b100, level_list {-1,3}, total_zeros 4, run_list {1,0,2,0}; out_valid 16 cycles after accept.
REQ-035 All-zero LUMA block -> all counts 0, lists zero, out_valid after 16 cycles.
REQ-036 CHROMA_DC raster {1,-1,1,1} -> total_coeff 4, t1_cnt 3, t1_sign 3'b100, level_list {1}, total_zeros 0; out_valid after 4 cycles.
REQ-037 AC, position 0 = 5 and others 0 -> total_coeff 0; in_mode 3 -> mode_err 1.
REQ-038 out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0; back-to-back in_valid accepted cycle after release.
REQ-039 rst asserted at scan cycle 7 -> immediate IDLE, outputs 0; next block processed correctly.
